mrv1_wb_arbiter: RTL and testbench
==================================

Name: mrv1_wb_arbiter

Overview:
- Shares the single register-file writeback port between NUM_TW_P thread-warps, each of which has one retirement result ready.
- Each cycle it selects one requesting thread by rotating round-robin priority and returns a one-hot grant, which the thread uses to advance its retire pointer.
- The granted result is captured into a one-entry output register that drives the RF write port under a valid/ready handshake.
- Sits between the per-thread retirement buffers and the RF write port; it replaces fixed-priority thread selection with fair, backpressure-aware arbitration.

Parameters:
- NUM_TW_P, 8, number of thread-warps (requesters); must be ≥2.
- DATA_WIDTH_P, 32, writeback data width.
- rf_addr_width_p, 5, RF destination address width.
- tid_width_lp, $clog2(NUM_TW_P), thread id width (derived).

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_ni  in  1  synchronous, active-low reset.
- req_vld_i  in  NUM_TW_P  per-thread retire request.
- req_we_i  in  NUM_TW_P  request writes the RF (0 = retire-only, no RF write).
- req_rd_addr_i  in  NUM_TW_P×rf_addr_width_p  destination register.
- req_data_i  in  NUM_TW_P×DATA_WIDTH_P  writeback data.
- req_gnt_o  out  NUM_TW_P  one-hot grant; zero or one bit set.
- flush_i  in  NUM_TW_P  per-thread kill.
- wb_vld_o  out  1  output register holds a valid entry.
- wb_we_o  out  1  RF write enable of the held entry.
- wb_tid_o  out  tid_width_lp  thread of the held entry.
- wb_rd_addr_o  out  rf_addr_width_p  destination register of the held entry.
- wb_data_o  out  DATA_WIDTH_P  data of the held entry.
- wb_rdy_i  in  1  RF port accepts the held entry this cycle.
- stall_cnt_o  out  16  saturating count of cycles with wb_vld_o=1 and wb_rdy_i=0.

Behaviour:
- Reset (rst_ni=0 sampled at a clock edge):
  - wb_vld_o=0; wb_we_o=0; wb_tid_o=0; wb_rd_addr_o=0; wb_data_o=0.
  - Priority pointer=0; stall_cnt_o=0.
  - req_gnt_o is forced to 0 while rst_ni=0.
  - Reset mid-transfer drops the held entry with no completion.
- Eligibility: eff_req[i] = req_vld_i[i] & ~flush_i[i].
- Slot free: slot_free = ~wb_vld_o | wb_rdy_i.
- Grant (combinational, same cycle):
  - If slot_free and any eff_req is set, grant the first set bit found scanning from the pointer upward, wrapping modulo NUM_TW_P.
  - Otherwise req_gnt_o=0.
- Requester contract: a thread holds req_vld_i and its payload stable until it sees its grant. It consumes exactly one result per grant cycle.
- Capture (next edge after a grant):
  - wb_vld_o=1, wb_tid_o=granted index, wb_we_o/wb_rd_addr_o/wb_data_o copied from the granted thread.
  - Pointer becomes (granted index + 1) mod NUM_TW_P.
  - Latency from request to wb_vld_o is 1 cycle when the slot is free.
- Drain:
  - If wb_vld_o & wb_rdy_i and there is no grant this cycle, wb_vld_o→0 next edge.
  - Accept and a new grant in the same cycle give back-to-back entries, one per cycle at full throughput.
- Stall: while wb_vld_o & ~wb_rdy_i, the output register holds all fields, req_gnt_o=0 and the pointer holds.
- Retire-only entries (we=0) occupy the slot for one accept like any other entry. wb_we_o=0 tells the RF to ignore the data.
- Flush:
  - A flushed thread is never granted that cycle.
  - If flush_i[wb_tid_o] & wb_vld_o, the held entry is killed: wb_vld_o→0 next edge unless a new grant is captured. The kill takes priority over wb_rdy_i, and the killed entry counts as neither accepted nor stalled.
  - The pointer is not affected by flush.
- stall_cnt_o increments by 1 on each stall cycle and saturates at 16'hFFFF.
- Fairness: with all threads continuously requesting and wb_rdy_i=1, each thread is granted exactly once per NUM_TW_P cycles.

Test Plan:
- Reset mid-transfer: hold wb_rdy_i=0 with an entry held, then drive rst_ni=0 for 1 cycle → wb_vld_o=0, stall_cnt_o=0, next grant goes to the lowest requesting index at or above 0.
- Full round-robin: all 8 req_vld_i=1, wb_rdy_i=1 → grants 0,1,…,7,0 on consecutive cycles; wb_tid_o follows one cycle later; wb_vld_o stays 1 continuously.
- Sparse requests: only threads 2 and 5 request, with the pointer at 3 → grant 5 first, then 2; wb_rd_addr_o and wb_data_o match each thread's payload.
- Backpressure: thread 4 granted, then wb_rdy_i=0 for 3 cycles → req_gnt_o=0 for those 3 cycles, outputs held stable, stall_cnt_o=3; on wb_rdy_i=1 the next grant issues in the same cycle.
- Flush: thread 6 held with wb_rdy_i=0, then assert flush_i[6] while thread 6 still requests → entry dropped next edge, thread 6 not granted, other requesters granted.
- Retire-only and saturation: req_we_i=0 request → wb_vld_o=1 with wb_we_o=0; force 70000 stall cycles → stall_cnt_o=16'hFFFF.

Source files
------------

// File: rtl/mrv1_wb_arbiter.sv
// Writeback arbiter: round-robin selection among thread-warp retire requests,
// captured into a one-entry output register feeding the RF write port.
module mrv1_wb_arbiter #(
  parameter  int NUM_TW_P        = 8,
  parameter  int DATA_WIDTH_P    = 32,
  parameter  int rf_addr_width_p = 5,
  localparam int tid_width_lp    = $clog2(NUM_TW_P)
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic [NUM_TW_P-1:0]                   req_vld_i,
  input  logic [NUM_TW_P-1:0]                   req_we_i,
  input  logic [NUM_TW_P*rf_addr_width_p-1:0]   req_rd_addr_i,
  input  logic [NUM_TW_P*DATA_WIDTH_P-1:0]      req_data_i,
  output logic [NUM_TW_P-1:0]                   req_gnt_o,
  input  logic [NUM_TW_P-1:0]                   flush_i,
  output logic                                  wb_vld_o,
  output logic                                  wb_we_o,
  output logic [tid_width_lp-1:0]               wb_tid_o,
  output logic [rf_addr_width_p-1:0]            wb_rd_addr_o,
  output logic [DATA_WIDTH_P-1:0]               wb_data_o,
  input  logic                                  wb_rdy_i,
  output logic [15:0]                           stall_cnt_o
);

  // state    | meaning
  // ST_EMPTY | output register holds nothing; slot free
  // ST_HELD  | output register holds an entry awaiting wb_rdy_i
  typedef enum logic {ST_EMPTY, ST_HELD} state_e;

  state_e                    state_q, state_d;
  logic [tid_width_lp-1:0]   ptr_q;
  logic [NUM_TW_P-1:0]       eff_req;
  logic                      slot_free;
  logic                      kill;
  logic                      stall;
  logic                      gnt_found;
  logic                      gnt_vld;
  logic [tid_width_lp-1:0]   gnt_idx;
  logic                      load;
  int                        cand;

  assign eff_req   = req_vld_i & ~flush_i;
  assign slot_free = ~wb_vld_o | wb_rdy_i;
  assign kill      = wb_vld_o & flush_i[wb_tid_o];
  // A killed entry is neither accepted nor stalled.
  assign stall     = wb_vld_o & ~wb_rdy_i & ~kill;
  assign wb_vld_o  = (state_q == ST_HELD);

  // Rotating priority search starting at the pointer, wrapping modulo NUM_TW_P.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = 0;
    for (int i = 0; i < NUM_TW_P; i++) begin
      cand = int'(ptr_q) + i;
      if (cand >= NUM_TW_P) cand = cand - NUM_TW_P;
      if (!gnt_found && eff_req[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = tid_width_lp'(cand);
      end
    end
  end

  assign gnt_vld = rst_ni & slot_free & gnt_found;

  always_comb begin
    req_gnt_o = '0;
    if (gnt_vld) req_gnt_o[gnt_idx] = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) state_q <= ST_EMPTY;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (gnt_vld) begin
          state_d = ST_HELD;
          load    = 1'b1;
        end
      end
      ST_HELD: begin
        if (gnt_vld) begin
          state_d = ST_HELD;
          load    = 1'b1;
        end else if (kill || wb_rdy_i) begin
          state_d = ST_EMPTY;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wb_we_o      <= 1'b0;
      wb_tid_o     <= '0;
      wb_rd_addr_o <= '0;
      wb_data_o    <= '0;
    end else if (load) begin
      wb_we_o      <= req_we_i[gnt_idx];
      wb_tid_o     <= gnt_idx;
      wb_rd_addr_o <= req_rd_addr_i[gnt_idx*rf_addr_width_p +: rf_addr_width_p];
      wb_data_o    <= req_data_i[gnt_idx*DATA_WIDTH_P +: DATA_WIDTH_P];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else if (gnt_vld) begin
      if (gnt_idx == tid_width_lp'(NUM_TW_P - 1)) ptr_q <= '0;
      else                                        ptr_q <= gnt_idx + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni)                              stall_cnt_o <= '0;
    else if (stall && stall_cnt_o != 16'hFFFF) stall_cnt_o <= stall_cnt_o + 16'd1;
  end

endmodule

// File: tb/tb_mrv1_wb_arbiter.sv
// Directed bench for mrv1_wb_arbiter: reset, round-robin, sparse requests,
// backpressure, flush, retire-only, stall saturation and mid-transfer reset.
module tb_mrv1_wb_arbiter;

  localparam int N  = 8;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int TW = 3;

  logic            clk;
  logic            rst_n;
  logic [N-1:0]    req_vld;
  logic [N-1:0]    req_we;
  logic [N*AW-1:0] req_rd_addr;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_gnt;
  logic [N-1:0]    flush;
  logic            wb_vld;
  logic            wb_we;
  logic [TW-1:0]   wb_tid;
  logic [AW-1:0]   wb_rd_addr;
  logic [DW-1:0]   wb_data;
  logic            wb_rdy;
  logic [15:0]     stall_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  mrv1_wb_arbiter #(
    .NUM_TW_P(N), .DATA_WIDTH_P(DW), .rf_addr_width_p(AW)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_vld_i(req_vld), .req_we_i(req_we), .req_rd_addr_i(req_rd_addr),
    .req_data_i(req_data), .req_gnt_o(req_gnt), .flush_i(flush),
    .wb_vld_o(wb_vld), .wb_we_o(wb_we), .wb_tid_o(wb_tid),
    .wb_rd_addr_o(wb_rd_addr), .wb_data_o(wb_data), .wb_rdy_i(wb_rdy),
    .stall_cnt_o(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] exp_data(input int i);
    return 32'hA500_0000 | (32'(i) * 32'h0101);
  endfunction

  function automatic logic [31:0] exp_addr(input int i);
    logic [AW-1:0] a;
    a = AW'(i + 3);
    return 32'(a);
  endfunction

  function automatic logic [31:0] one_hot(input int i);
    return 32'h1 << i;
  endfunction

  initial begin
    rst_n   = 1'b0;
    req_vld = '0;
    req_we  = '1;
    flush   = '0;
    wb_rdy  = 1'b1;
    for (int i = 0; i < N; i++) begin
      req_data[i*DW +: DW]    = exp_data(i);
      req_rd_addr[i*AW +: AW] = AW'(i + 3);
    end

    // Reset: outputs cleared, grant forced low even with requests pending.
    step();
    req_vld = '1;
    #1;
    chk("rst_gnt", 32'(req_gnt), 32'h0);
    step();
    chk("rst_vld",   32'(wb_vld), 32'h0);
    chk("rst_data",  wb_data, 32'h0);
    chk("rst_tid",   32'(wb_tid), 32'h0);
    chk("rst_stall", 32'(stall_cnt), 32'h0);

    // Full round-robin: 0..7,0 on consecutive cycles.
    rst_n = 1'b1;
    for (int k = 0; k < 9; k++) begin
      #1;
      chk("rr_gnt", 32'(req_gnt), one_hot(k % N));
      step();
      chk("rr_tid",  32'(wb_tid), 32'(k % N));
      chk("rr_vld",  32'(wb_vld), 32'h1);
      chk("rr_data", wb_data, exp_data(k % N));
    end
    chk("rr_we", 32'(wb_we), 32'h1);

    // Drain, then move the pointer to 3 by granting thread 2 alone.
    req_vld = '0;
    step();
    chk("drain_vld", 32'(wb_vld), 32'h0);
    req_vld = 8'b0000_0100;
    #1;
    chk("sp_pre_gnt", 32'(req_gnt), one_hot(2));
    step();
    req_vld = '0;
    step();

    // Sparse: threads 2 and 5 with pointer at 3 -> 5 then 2.
    req_vld = 8'b0010_0100;
    #1;
    chk("sp_gnt5", 32'(req_gnt), one_hot(5));
    step();
    chk("sp_tid5",  32'(wb_tid), 32'h5);
    chk("sp_addr5", 32'(wb_rd_addr), exp_addr(5));
    chk("sp_data5", wb_data, exp_data(5));
    req_vld = 8'b0000_0100;
    #1;
    chk("sp_gnt2", 32'(req_gnt), one_hot(2));
    step();
    chk("sp_tid2",  32'(wb_tid), 32'h2);
    chk("sp_addr2", 32'(wb_rd_addr), exp_addr(2));
    chk("sp_data2", wb_data, exp_data(2));
    req_vld = '0;
    step();
    chk("sp_drain", 32'(wb_vld), 32'h0);

    // Backpressure: thread 4 held through 3 stall cycles, thread 1 waiting.
    req_vld = 8'b0001_0000;
    #1;
    chk("bp_gnt4", 32'(req_gnt), one_hot(4));
    step();
    req_vld = 8'b0000_0010;
    wb_rdy  = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("bp_gnt0", 32'(req_gnt), 32'h0);
      step();
      chk("bp_tid",  32'(wb_tid), 32'h4);
      chk("bp_data", wb_data, exp_data(4));
    end
    chk("bp_stall", 32'(stall_cnt), 32'h3);
    wb_rdy = 1'b1;
    #1;
    chk("bp_gnt1", 32'(req_gnt), one_hot(1));
    step();
    chk("bp_tid1", 32'(wb_tid), 32'h1);
    req_vld = '0;
    step();
    chk("bp_stall_hold", 32'(stall_cnt), 32'h3);

    // Flush: thread 6 held, then killed while still requesting; thread 3 wins.
    req_vld = 8'b0100_0000;
    #1;
    chk("fl_gnt6", 32'(req_gnt), one_hot(6));
    step();
    wb_rdy  = 1'b0;
    req_vld = 8'b0100_1000;
    flush   = 8'b0100_0000;
    #1;
    chk("fl_gnt0", 32'(req_gnt), 32'h0);
    step();
    chk("fl_vld",   32'(wb_vld), 32'h0);
    chk("fl_stall", 32'(stall_cnt), 32'h3);
    #1;
    chk("fl_gnt3", 32'(req_gnt), one_hot(3));
    step();
    chk("fl_tid3", 32'(wb_tid), 32'h3);
    chk("fl_vld3", 32'(wb_vld), 32'h1);
    flush   = '0;
    req_vld = '0;
    wb_rdy  = 1'b1;
    step();

    // Retire-only entry, then saturate the stall counter.
    req_we  = 8'b1111_1110;
    req_vld = 8'b0000_0001;
    #1;
    chk("ro_gnt0", 32'(req_gnt), one_hot(0));
    step();
    chk("ro_vld", 32'(wb_vld), 32'h1);
    chk("ro_we",  32'(wb_we), 32'h0);
    req_vld = '0;
    wb_rdy  = 1'b0;
    repeat (70000) step();
    chk("sat_stall", 32'(stall_cnt), 32'hFFFF);
    chk("sat_vld",   32'(wb_vld), 32'h1);

    // Mid-transfer reset: entry dropped, counter and pointer cleared.
    rst_n   = 1'b0;
    req_vld = 8'b0000_0101;
    #1;
    chk("mr_gnt_rst", 32'(req_gnt), 32'h0);
    step();
    chk("mr_vld",   32'(wb_vld), 32'h0);
    chk("mr_stall", 32'(stall_cnt), 32'h0);
    rst_n  = 1'b1;
    wb_rdy = 1'b1;
    #1;
    chk("mr_gnt", 32'(req_gnt), one_hot(0));
    step();
    chk("mr_tid", 32'(wb_tid), 32'h0);
    req_vld = '0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
